// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : 8-way round-robin arbiter, registered one-hot grant + index.
//            Optional forced release after MAX_HOLD cycles: ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module rr_arbiter8 #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic [2:0]        idx_nxt;
  logic              valid_nxt;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [2:0]        offset;
  logic [2:0]        sel;
  logic              at_limit;

  if (NREQ != 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_arbiter8: NREQ must be 8 and MAX_HOLD in 2..255");
  end

  // Rotate so that bit 0 of req_rot is the requester at ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NREQ];

  always_comb begin
    offset = 3'd0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) offset = 3'(j);
    end
  end

  assign sel = ptr + offset;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               hold_cnt <= 8'd0;
    else if (state == IDLE)   hold_cnt <= 8'd0;
    else if (!done)           hold_cnt <= hold_cnt + 8'd1;
  end

  assign at_limit = (state == BUSY) && (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout <= 1'b0;
    else        timeout <= at_limit && !done;
  end
`else
  assign at_limit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = NREQ'(1) << sel;
          idx_nxt   = sel;
          valid_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Release always passes through IDLE, giving the bus one dead cycle.
        if (done || at_limit) begin
          grant_nxt = '0;
          idx_nxt   = 3'd0;
          valid_nxt = 1'b0;
          ptr_nxt   = grant_idx + 3'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      grant       <= '0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Purpose  : Scoreboard bench for rr_arbiter8 against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  rr_arbiter8 #(.NREQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic       m_busy;
  logic [2:0] m_idx;
  logic [2:0] m_ptr;
`ifdef ARB_TIMEOUT_EN
  int         m_cnt;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 3'd0;
    m_ptr  = 3'd0;
`ifdef ARB_TIMEOUT_EN
    m_cnt  = 0;
`endif
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, output exp_t e);
    logic to;
    to = 1'b0;
    if (!m_busy) begin
      if (r != 8'd0) begin
        int k;
        k = m_ptr;
        while (!r[k]) k = (k + 1) % 8;
        m_busy = 1'b1;
        m_idx  = 3'(k);
`ifdef ARB_TIMEOUT_EN
        m_cnt  = 0;
`endif
      end
    end else if (d) begin
      m_busy = 1'b0;
      m_ptr  = 3'((m_idx + 1) % 8);
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1) begin
        m_busy = 1'b0;
        m_ptr  = 3'((m_idx + 1) % 8);
        to     = 1'b1;
      end else begin
        m_cnt++;
      end
`endif
    end
    e.g = m_busy ? (8'd1 << m_idx) : 8'd0;
    e.i = m_busy ? m_idx : 3'd0;
    e.v = m_busy;
    e.t = to;
  endtask

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("grant",       32'(grant),       32'(e.g));
      check("grant_idx",   32'(grant_idx),   32'(e.i));
      check("grant_valid", 32'(grant_valid), 32'(e.v));
      check("timeout",     32'(timeout),     32'(e.t));
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    model_step(r, d, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant),       32'd0);
    check({tag, "_idx"},   32'(grant_idx),   32'd0);
    check({tag, "_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_to"},    32'(timeout),     32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'd0;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // Single requester 2, then release -> ptr 3
    step(8'b0000_0100, 1'b0);
    step(8'b0000_0000, 1'b1);

    // Wrap scan from ptr 3 picks 0, then bit 2 next
    step(8'b0000_0101, 1'b0);
    step(8'b0000_0101, 1'b1);
    step(8'b0000_0101, 1'b0);
    step(8'b0000_0000, 1'b1);

    // Owner 5 drops req while bit 1 rises: grant must stay frozen
    step(8'b0010_0000, 1'b0);
    for (int n = 0; n < 4; n++) step(8'b0000_0010, 1'b0);
    step(8'b0000_0010, 1'b1);
    step(8'b0000_0000, 1'b0);
    step(8'b0000_0000, 1'b1);
    step(8'b0000_0000, 1'b1);

    // Asynchronous reset in the middle of a grant
    step(8'b0001_0000, 1'b0);
    step(8'b0000_0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(8'h80, 1'b0);
    step(8'h00, 1'b1);

    // All requesting: 0..7,0 with one idle cycle per release
    for (int n = 0; n < 9; n++) begin
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end

    // Long hold without done
    step(8'b0000_1000, 1'b0);
    for (int n = 0; n < 100; n++) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Produces a registered one-hot grant vector plus its 3-bit encoded index, so the resource sees both forms.
- The index path replaces the combinational 8-to-3 encoding previously done downstream; one-hot grant and index are always consistent.
- Sits between requesting engines and the shared resource; the resource signals completion with done.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 in this revision, because the index is 3 bits.
- MAX_HOLD, 16, cycles a grant may be held before forced release; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  resource finished with the current owner; honoured only while grant_valid=1.
- grant  output  8  registered one-hot grant; all zeros when idle.
- grant_idx  output  3  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Round-robin pointer ptr=0, state=IDLE, hold counter=0.
  - Asserting reset mid-grant clears all outputs immediately, without waiting for a clock edge.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0 at a rising edge, select the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1.
  - On that same edge, load grant=one-hot(sel), grant_idx=sel, grant_valid=1, and go to BUSY.
  - If req=0, stay in IDLE with outputs at 0.
- Latency: req visible at edge k gives outputs valid after edge k; nothing is registered ahead of req.
- BUSY:
  - grant, grant_idx and ptr are frozen.
  - req changes are ignored, including the owner dropping its own req; the owner is released only by done (or timeout).
  - done=1 at an edge clears grant, grant_idx and grant_valid, sets ptr=(grant_idx+1) mod 8, and returns to IDLE.
- Bus turnaround: at least one idle cycle (grant=0) always separates two grants, even when other requests are pending.
- Wrap-around: owner 7 releases and ptr becomes 0.
- Fairness: with all 8 requesting continuously, grants go 0,1,…,7,0,… and each requester waits at most 7 grants.
- done while IDLE: ignored, with no state change.
- done and a new req in the same edge while BUSY: the release is taken; the new req is arbitrated from IDLE on a later edge.
- Invariant: grant has at most one bit set, and grant_idx always encodes it.
- Output X is never driven.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The BUSY hold counter starts at 0 on grant and increments each cycle that done=0.
  - When the count reaches MAX_HOLD-1 and done=0, the next edge performs a forced release: same effect as done, including ptr advance.
  - timeout=1 for exactly that one cycle.
  - done takes priority over timeout on the same edge; no timeout pulse is generated then.
- When undefined:
  - No counter is present.
  - timeout is constant 0.
  - A grant is held indefinitely until done.

Test Plan:
- Reset then req=8'b0000_0100 → next edge grant=8'b0000_0100, grant_idx=2, grant_valid=1; assert done 1 cycle → grant=0, ptr=3.
- req=8'hFF held, done pulsed once per grant → grant_idx sequence 0,1,2,3,4,5,6,7,0, with exactly one idle cycle between grants.
- ptr=3 (after owner 2) with req=8'b0000_0101 → grant_idx=0 (wrap scan 3..7 then 0); after its release, req bit 2 is granted next.
- While owner 5 is granted, it drops req and bit 1 rises → grant stays 8'b0010_0000 until done; done while IDLE has no effect.
- Assert rst_n=0 mid-grant between clock edges → grant, grant_idx, grant_valid are 0 immediately; after release, req=8'h80 yields grant_idx=7 (ptr reset to 0).
- With ARB_TIMEOUT_EN and MAX_HOLD=16, done held 0 → release after 16 cycles in BUSY, timeout pulses 1 cycle, ptr advances; without the macro, grant is still held at 100 cycles and timeout=0.
